// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - display pin and pair-decoder bundle of the scan controller
interface display_scan_ctrl_if;
  logic [7:0]  pair_bcd;
  logic [13:0] seg_pair;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  src_mode;

  modport master (
    output pair_bcd,
    output an,
    output seg,
    output dp,
    output src_mode,
    input  seg_pair
  );

  modport slave (
    input  pair_bcd,
    input  an,
    input  seg,
    input  dp,
    input  src_mode,
    output seg_pair
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit seven-segment scan with guard cycle, edit blink and BCD blanking
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [15:0]          bcd_clock,
  input  logic [15:0]          bcd_alarm,
  input  logic [15:0]          bcd_stopwatch,
  input  logic [15:0]          bcd_timer,
  input  logic                 edit_en,
  input  logic                 edit_field,
  display_scan_ctrl_if.master  disp
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    SLOT_MIN_ONES = 2'd0,
    SLOT_MIN_TENS = 2'd1,
    SLOT_HR_ONES  = 2'd2,
    SLOT_HR_TENS  = 2'd3
  } slot_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  slot_t         slot_q;
  slot_t         slot_d;
  logic [15:0]   frame_data;
  logic [15:0]   sel_bcd;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          edit_en_q;
  logic          edit_field_q;
  logic          edit_edge;

  logic [3:0]    nib;
  logic [6:0]    dig_seg;
  logic          guard;
  logic          blink_off;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign tick = (div_cnt == DW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_MIN_ONES;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      case (slot_q)
        SLOT_MIN_ONES: slot_d = SLOT_MIN_TENS;
        SLOT_MIN_TENS: slot_d = SLOT_HR_ONES;
        SLOT_HR_ONES:  slot_d = SLOT_HR_TENS;
        default:       slot_d = SLOT_MIN_ONES;
      endcase
    end
  end

  always_comb begin
    sel_bcd = bcd_clock;
    case (mode)
      2'b01:   sel_bcd = bcd_alarm;
      2'b10:   sel_bcd = bcd_stopwatch;
      2'b11:   sel_bcd = bcd_timer;
      default: sel_bcd = bcd_clock;
    endcase
  end

  // Source is only taken as the last digit of a frame ends, so a frame never mixes two sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp.src_mode <= 2'b00;
      frame_data    <= 16'h0000;
    end else if (tick && slot_q == SLOT_HR_TENS) begin
      disp.src_mode <= mode;
      frame_data    <= sel_bcd;
    end
  end

  assign edit_edge = (edit_en ^ edit_en_q) | (edit_field ^ edit_field_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edit_en_q    <= 1'b0;
      edit_field_q <= 1'b0;
      blink_cnt    <= '0;
      blink_ph     <= 1'b0;
    end else begin
      edit_en_q    <= edit_en;
      edit_field_q <= edit_field;
      if (edit_edge) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign disp.pair_bcd = slot_q[1] ? frame_data[15:8] : frame_data[7:0];

  always_comb begin
    nib = frame_data[3:0];
    case (slot_q)
      SLOT_MIN_TENS: nib = frame_data[7:4];
      SLOT_HR_ONES:  nib = frame_data[11:8];
      SLOT_HR_TENS:  nib = frame_data[15:12];
      default:       nib = frame_data[3:0];
    endcase
  end

  // An edit edge in this very cycle already counts as phase 0, keeping the field lit at once.
  always_comb begin
    dig_seg   = slot_q[0] ? disp.seg_pair[13:7] : disp.seg_pair[6:0];
    guard     = (div_cnt == '0);
    blink_off = edit_en & blink_ph & ~edit_edge & (slot_q[1] == edit_field);
    an_d      = (guard | blink_off) ? 4'b1111 : ~(4'b0001 << slot_q);
    seg_d     = (nib > 4'd9) ? 7'h7F : dig_seg;
    dp_d      = ~((slot_q == SLOT_HR_ONES) & ~guard & ~blink_off);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp.an  <= 4'b1111;
      disp.seg <= 7'h7F;
      disp.dp  <= 1'b1;
    end else begin
      disp.an  <= an_d;
      disp.seg <= seg_d;
      disp.dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed plus random bench for display_scan_ctrl against a timeline model
module tb_display_scan_ctrl;

  localparam int R = 4;
  localparam int B = 8;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] bcd_clock;
  logic [15:0] bcd_alarm;
  logic [15:0] bcd_stopwatch;
  logic [15:0] bcd_timer;
  logic        edit_en;
  logic        edit_field;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl_if dif ();

  display_scan_ctrl #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .bcd_clock     (bcd_clock),
    .bcd_alarm     (bcd_alarm),
    .bcd_stopwatch (bcd_stopwatch),
    .bcd_timer     (bcd_timer),
    .edit_en       (edit_en),
    .edit_field    (edit_field),
    .disp          (dif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h01;
      4'd1: return 7'h4F;
      4'd2: return 7'h12;
      4'd3: return 7'h06;
      4'd4: return 7'h4C;
      4'd5: return 7'h24;
      4'd6: return 7'h20;
      4'd7: return 7'h0F;
      4'd8: return 7'h00;
      4'd9: return 7'h04;
      default: return 7'h2A;
    endcase
  endfunction

  // Ideal pair decoder; non-BCD codes yield junk the controller must hide.
  assign dif.seg_pair = {seg7(dif.pair_bcd[7:4]), seg7(dif.pair_bcd[3:0])};

  // Model: everything derived from elapsed cycles since reset and since the last edit edge.
  int          m_n;
  int          m_age;
  logic [15:0] m_frm;
  logic [1:0]  m_src;
  logic        m_pen;
  logic        m_pfld;

  function automatic int m_div();  return m_n % R;                      endfunction
  function automatic int m_slot(); return (m_n / R) % 4;                endfunction
  function automatic int m_ph();   return (m_age / B) % 2;              endfunction

  function automatic logic [15:0] m_sel(input logic [1:0] md);
    case (md)
      2'd0: return bcd_clock;
      2'd1: return bcd_alarm;
      2'd2: return bcd_stopwatch;
      default: return bcd_timer;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0; m_age = 0; m_frm = 16'h0000; m_src = 2'b00; m_pen = 1'b0; m_pfld = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    int          s;
    logic        edge_now;
    logic        guard;
    logic        blank;
    logic [3:0]  nib;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    s        = m_slot();
    edge_now = (edit_en != m_pen) || (edit_field != m_pfld);
    guard    = (m_div() == 0);
    blank    = edit_en && (m_ph() == 1) && !edge_now && ((s >= 2) == edit_field);
    nib      = 4'((m_frm >> (4 * s)) & 16'hF);
    e_an     = (guard || blank) ? 4'b1111 : ~(4'b0001 << s);
    e_seg    = (nib > 4'd9) ? 7'h7F : seg7(nib);
    e_dp     = !(s == 2 && !guard && !blank);
    if (m_n % (4 * R) == 4 * R - 1) begin
      m_frm = m_sel(mode);
      m_src = mode;
    end
    m_n++;
    m_age  = edge_now ? 0 : m_age + 1;
    m_pen  = edit_en;
    m_pfld = edit_field;
    @(posedge clk);
    #1;
    chk("an", 16'(dif.an), 16'(e_an));
    chk("seg", 16'(dif.seg), 16'(e_seg));
    chk("dp", 16'(dif.dp), 16'(e_dp));
    chk("pair_bcd", 16'(dif.pair_bcd), (m_slot() >= 2) ? 16'(m_frm[15:8]) : 16'(m_frm[7:0]));
    chk("src_mode", 16'(dif.src_mode), 16'(m_src));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; edit_en = 1'b0; edit_field = 1'b0;
    bcd_clock = 16'h0000; bcd_alarm = 16'h0000; bcd_stopwatch = 16'h0000; bcd_timer = 16'h0000;
    model_reset();
    #12;
    chk("rst_an", 16'(dif.an), 16'h000F);
    chk("rst_seg", 16'(dif.seg), 16'h007F);
    chk("rst_dp", 16'(dif.dp), 16'h0001);
    chk("rst_pair", 16'(dif.pair_bcd), 16'h0000);
    #1 rst_n = 1'b1;

    // 23:59 from the clock source, two full frames after the first latch
    bcd_clock = 16'h2359;
    run(48);

    // switch to alarm mid slot 1; current frame must finish as 23:59
    for (int i = 0; i < 64 && !(m_slot() == 1 && m_div() == 1); i++) step();
    mode = 2'b01; bcd_alarm = 16'h0730;
    run(40);

    // invalid minutes-ones nibble must blank that digit only
    mode = 2'b00; bcd_clock = 16'h125A;
    run(40);

    // hours blinking
    bcd_clock = 16'h2359; edit_field = 1'b1; edit_en = 1'b1;
    run(48);

    // rising edit_en while phase is 1 restarts the blink
    edit_en = 1'b0;
    step();
    for (int i = 0; i < 64 && m_ph() != 1; i++) step();
    edit_en = 1'b1;
    run(20);
    edit_field = 1'b0;
    run(40);

    // random sources, modes and edit activity
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bcd_clock = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_alarm = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_stopwatch = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_timer = 16'($urandom);
      if ($urandom_range(0, 39) == 0) edit_en = ~edit_en;
      if ($urandom_range(0, 39) == 0) edit_field = ~edit_field;
      step();
    end

    // asynchronous reset pulse during slot 2
    edit_en = 1'b0; mode = 2'b00; bcd_clock = 16'h2359;
    for (int i = 0; i < 64 && !(m_slot() == 2 && m_div() == 1); i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 16'(dif.an), 16'h000F);
    chk("arst_seg", 16'(dif.seg), 16'h007F);
    chk("arst_dp", 16'(dif.dp), 16'h0001);
    #7 rst_n = 1'b1;
    model_reset();
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for the 4-digit common-anode seven-segment display.
- Each frame it latches one HH:MM BCD source selected by the clock mode.
- It sequences the source's minute and hour pairs through the external two-digit pair decoder and drives the anodes one digit per slot.
- It adds a ghost-suppression guard cycle, edit-field blinking and invalid-BCD blanking.
- It sits between the mode/timekeeping logic and the board display pins.

## Interface
- REFRESH_DIV, 100000, clk cycles per digit slot (≥2)
- BLINK_DIV, 25000000, clk cycles per blink phase toggle (≥2)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  00 clock, 01 alarm, 10 stopwatch, 11 timer
- bcd_clock, bcd_alarm, bcd_stopwatch, bcd_timer  in  16 each  {HH tens, HH ones, MM tens, MM ones} BCD
- edit_en  in  1  edit active; selected field blinks
- edit_field  in  1  0 = minutes blink, 1 = hours blink
- pair_bcd  out  8  BCD pair to pair decoder (combinational from slot and frame data)
- seg_pair  in  14  decoder result: [13:7] tens digit, [6:0] ones digit, abcdefg, active-low
- an  out  4  anodes, active-low, an[0] = rightmost digit
- seg  out  7  segments abcdefg, active-low
- dp  out  1  decimal point, active-low

## Operation
- div_cnt counts 0..REFRESH_DIV-1 and wraps. The cycle with div_cnt == REFRESH_DIV-1 is the tick.
- slot (2 bits) advances on tick, mod 4: 0 min ones, 1 min tens, 2 hr ones, 3 hr tens.
- Frame latch:
  - On tick with slot == 3, src_mode <= mode and frame_data <= the bcd_* bus selected by mode, captured in the same cycle.
  - Mode or data changes mid-frame never tear a frame.
- pair_bcd = frame_data[7:0] for slots 0–1, frame_data[15:8] for slots 2–3.
- Digit segments:
  - Slots 0 and 2 take seg_pair[6:0]; slots 1 and 3 take seg_pair[13:7].
  - If the digit's own nibble is > 9, seg = 7'h7F (blank) regardless of seg_pair, because the decoder has no defined output for such codes.
- Guard: while div_cnt == 0, an = 4'b1111 (all digits off).
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1; blink_ph toggles at wrap.
  - Any edge of edit_en, or any edge of edit_field, clears blink_cnt and blink_ph, so the field is visible immediately.
  - When edit_en = 1 and blink_ph = 1, slots of the selected field (0–1 for minutes, 2–3 for hours) have an = 4'b1111.
- dp = 0 in slot 2 (colon substitute) unless that digit is blanked by guard or blink; otherwise dp = 1.
- Otherwise an = ~(4'b0001 << slot).

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - div_cnt = 0, slot = 0, blink_cnt = 0, blink_ph = 0
  - src_mode = 00, frame_data = 16'h0000
  - an = 4'b1111, seg = 7'h7F, dp = 1
- an, seg and dp are registered. They reflect the slot, div_cnt, blink and frame state of the previous cycle, giving 1 cycle of latency.
- One digit is lit for REFRESH_DIV-1 of REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles.
- Frame data updates on the tick that leaves slot 3. The first slot-0 output using the new data appears 1 cycle after the guard cycle of that slot begins.
- When tick and an edit_en edge fall in the same cycle, both take effect; the blink reset has priority over the blink toggle.
- Reset deasserted mid-frame: the scan restarts at slot 0 with frame_data = 0. The first real frame latch occurs after 4·REFRESH_DIV cycles, so 00:00 is displayed until then.
- seg_pair is sampled in the same cycle pair_bcd is driven; the decoder path must be purely combinational.

## Test plan
- REFRESH_DIV=4, mode=00, bcd_clock=16'h2359, ideal decoder model:
  - After the first frame latch, an cycles 1110→1101→1011→0111, each lit 3 cycles with 1 guard cycle of 1111.
  - seg shows 9,5,3,2 in that order.
  - dp = 0 only while an = 1011.
- Mode switch from 00 to 01 in mid slot 1 with bcd_alarm=16'h0730 -> the current frame still shows 23:59; the next frame shows 07:30 starting at slot 0.
- frame_data minutes = 8'h5A -> slot 0 seg = 7'h7F with an = 1110; slot 1 shows 5 normally.
- BLINK_DIV=8, edit_en=1, edit_field=1 -> in alternating 8-cycle phases, an never goes low for digits 2/3 during phase 1, while minutes digits scan normally throughout.
- edit_en toggled 0→1 while blink_ph = 1 -> blink_ph = 0 on the next cycle, and the hours digits are visible for the next 8 cycles.
- rst_n pulsed low for 1 cycle during slot 2 -> an = 1111, seg = 7'h7F, dp = 1 immediately (asynchronous); the scan resumes at slot 0 showing 00:00 until the next frame latch.
